// File: rtl/bus_initiator.sv
// HuC6280 CPU-side bus initiator: MPR bank translation and a registered access FSM toward the memory/IO responder.
// Optional VDC_WAIT_EN inserts one SETUP cycle before accesses to physical 1FE000-1FE3FF.
module bus_initiator #(
    parameter logic [7:0] RST_MPR = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_laddr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_busy,
    input  logic        mpr_we,
    input  logic [2:0]  mpr_sel,
    input  logic [7:0]  mpr_wdata,
    output logic [7:0]  mpr_rdata,
    output logic [20:0] addr,
    output logic [7:0]  dIn,
    input  logic [7:0]  dOut,
    output logic        re,
    output logic        we,
    output logic        CE_n,
    output logic        CER_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [7:0] BANK_RAM = 8'hF8;
    localparam logic [7:0] BANK_IO  = 8'hFF;

    state_t      state_q, state_d;
    logic [7:0]  mpr_q [8];
    logic [20:0] phys_q, phys_d;
    logic        wr_q, wr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic [20:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic        re_q, re_d;
    logic        we_q, we_d;
    logic        ce_n_q, ce_n_d;
    logic        cer_n_q, cer_n_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        busy_q, busy_d;

    logic [20:0] xlat;
    logic        driving;
    logic [7:0]  bank_d;
    logic        unmapped_q;

    assign mpr_rdata  = mpr_q[mpr_sel];
    // Translation reads the MPR value before any same-cycle MPR write lands.
    assign xlat       = {mpr_q[cpu_laddr[15:13]], cpu_laddr[12:0]};
    assign unmapped_q = (phys_q[20:13] > BANK_RAM) && (phys_q[20:13] != BANK_IO);

    always_comb begin
        state_d = state_q;
        phys_d  = phys_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    phys_d  = xlat;
                    wr_d    = cpu_we;
                    wdata_d = cpu_wdata;
`ifdef VDC_WAIT_EN
                    state_d = (xlat[20:10] == 11'b11111111_000) ? S_SETUP : S_ACCESS;
`else
                    state_d = S_ACCESS;
`endif
                end
            end
            S_SETUP:   state_d = S_ACCESS;
            S_ACCESS:  state_d = wr_q ? S_DONE : S_CAPTURE;
            S_CAPTURE: begin
                rdata_d = unmapped_q ? 8'hFF : dOut;
                state_d = S_DONE;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered, so they are derived from the state being entered.
    always_comb begin
        driving = (state_d == S_SETUP) || (state_d == S_ACCESS) || (state_d == S_CAPTURE);
        bank_d  = phys_d[20:13];
        addr_d  = driving ? phys_d : addr_q;
        din_d   = driving ? wdata_d : din_q;
        ce_n_d  = !(driving && (bank_d < BANK_RAM));
        cer_n_d = !(driving && (bank_d == BANK_RAM));
        re_d    = (state_d == S_ACCESS) && !wr_d;
        we_d    = (state_d == S_ACCESS) && wr_d;
        ack_d   = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int unsigned i = 0; i < 8; i++) begin
                mpr_q[i] <= RST_MPR;
            end
            phys_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            ce_n_q  <= 1'b1;
            cer_n_q <= 1'b1;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mpr_we) begin
                mpr_q[mpr_sel] <= mpr_wdata;
            end
            phys_q  <= phys_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            re_q    <= re_d;
            we_q    <= we_d;
            ce_n_q  <= ce_n_d;
            cer_n_q <= cer_n_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    assign addr      = addr_q;
    assign dIn       = din_q;
    assign re        = re_q;
    assign we        = we_q;
    assign CE_n      = ce_n_q;
    assign CER_n     = cer_n_q;
    assign cpu_ack   = ack_q;
    assign cpu_rdata = rdata_q;
    assign cpu_busy  = busy_q;

endmodule
